fe_fifo_read_ctrl: RTL
======================

FE_FIFO_READ_CTRL -- requirements
Module: fe_fifo_read_ctrl

Interface
REQ-001 The block SHALL have one parameter: pFIFO_WIDTH, default 18, front-end FIFO entry width (bits [17:16] = command, [15:0] = time/data).
REQ-002 The block SHALL have the port cwusb_clk, input, 1 bit: sole clock.
REQ-003 The block SHALL have the port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have the port I_fifo_dout, input, pFIFO_WIDTH bits: FIFO read data, valid one cycle after O_fifo_rd.
REQ-005 The block SHALL have the port I_fifo_empty, input, 1 bit: FIFO empty flag.
REQ-006 The block SHALL have the port O_fifo_rd, output, 1 bit: FIFO read strobe, one cycle per entry.
REQ-007 The block SHALL have the port I_reg_rd, input, 1 bit: host byte-read pulse on the FIFO data register.
REQ-008 The block SHALL have the port O_reg_data, output, 8 bits: byte presented to the host, sampled in the I_reg_rd cycle.
REQ-009 The block SHALL have the port I_flush, input, 1 bit: discard held entry and restart.
REQ-010 The block SHALL have the port I_clear_status, input, 1 bit: clears O_empty_read.
REQ-011 The block SHALL have the port O_empty_read, output, 1 bit: sticky flag set when the host reads byte 0 with no entry held.
REQ-012 The block SHALL have the port O_entry_count, output, 16 bits: entries fully delivered since the last reset or flush.

Function
REQ-013 FSM states SHALL be IDLE (no entry held), WAIT (read issued, data pending) and READY (entry held in hold register, byte index 0..2).
REQ-014 In IDLE with !I_fifo_empty and !I_flush, the block SHALL assert O_fifo_rd for exactly one cycle and go to WAIT.
REQ-015 WAIT SHALL last exactly one cycle; on exit it SHALL latch I_fifo_dout into the hold register, set index=0 and go to READY.
REQ-016 O_reg_data SHALL be combinational from the hold register and index:
- index 0 -> {1'b1, 5'b0, hold[17:16]}
- index 1 -> hold[15:8]
- index 2 -> hold[7:0]
- IDLE/WAIT -> 8'h00.
REQ-017 I_reg_rd in READY SHALL increment index.
REQ-018 I_reg_rd in READY at index 2 SHALL:
- increment O_entry_count, saturating at 16'hFFFF;
- if !I_fifo_empty, assert O_fifo_rd in the same cycle and go to WAIT (prefetch);
- otherwise go to IDLE.
REQ-019 I_reg_rd in IDLE or WAIT SHALL set O_empty_read and return 8'h00, with no change to the FSM state or index.
REQ-020 O_fifo_rd SHALL never assert while I_fifo_empty is high, in WAIT, or in a cycle where I_flush is high.
REQ-021 I_flush SHALL:
- force IDLE next cycle;
- clear index, hold register and O_entry_count;
- take priority over simultaneous I_reg_rd, which is ignored (no count, no O_empty_read).
- Data returned for a read issued in the cycle before flush is discarded.
REQ-022 When I_clear_status and a set condition for O_empty_read coincide, set SHALL win.
REQ-023 Entries SHALL be delivered in FIFO order with no loss or duplication outside flush.

Reset
REQ-024 While reset_i is high, asynchronously:
- state = IDLE;
- O_fifo_rd = 0, O_empty_read = 0, O_entry_count = 0;
- index = 0, hold register = 0;
- O_reg_data = 8'h00.
REQ-025 Reset mid-entry (READY index 1 or 2) SHALL discard the held entry; the first byte read after reset SHALL be byte 0 of the next FIFO entry.

Verification
REQ-026 The bench SHALL cover: FIFO holds 0x2ABCD; host reads three bytes -> 0x82, 0xAB, 0xCD; O_entry_count = 1; one O_fifo_rd pulse.
REQ-027 The bench SHALL cover: two entries 0x1_0001 and 0x3_FFFF, back-to-back reads -> 0x81, 0x00, 0x01, 0x83, 0xFF, 0xFF; second O_fifo_rd coincides with the third I_reg_rd.
REQ-028 The bench SHALL cover: empty FIFO, host read -> O_reg_data = 0x00, O_empty_read = 1, O_fifo_rd never asserts; I_clear_status -> O_empty_read = 0.
REQ-029 The bench SHALL cover: I_flush asserted at index 1 together with I_reg_rd -> IDLE, O_entry_count = 0; next entry begins at byte 0.
REQ-030 The bench SHALL cover: 65,536 entries delivered -> O_entry_count holds 16'hFFFF.
REQ-031 The bench SHALL cover: reset_i pulsed asynchronously between clock edges in READY -> all outputs zero immediately; after release the first read returns byte 0 of a fresh entry.

Source files
------------

// File: rtl/fe_fifo_read_ctrl.sv
// Front-end FIFO read controller: serialises each 18-bit FIFO entry into three host-readable
// bytes, prefetching the next entry on the last byte read, with flush and a delivery counter.
module fe_fifo_read_ctrl #(
  parameter int pFIFO_WIDTH = 18
) (
  input  logic                   cwusb_clk,
  input  logic                   reset_i,
  input  logic [pFIFO_WIDTH-1:0] I_fifo_dout,
  input  logic                   I_fifo_empty,
  output logic                   O_fifo_rd,
  input  logic                   I_reg_rd,
  output logic [7:0]             O_reg_data,
  input  logic                   I_flush,
  input  logic                   I_clear_status,
  output logic                   O_empty_read,
  output logic [15:0]            O_entry_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             index_q, index_d;
  logic [pFIFO_WIDTH-1:0] hold_q, hold_d;
  logic [15:0]            entry_count_q, entry_count_d;
  logic                   empty_read_q, empty_read_d;
  logic                   fifo_rd;

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    hold_d        = hold_q;
    entry_count_d = entry_count_q;
    empty_read_d  = empty_read_q;
    fifo_rd       = 1'b0;

    // A clear and a new empty-read in the same cycle leave the flag set.
    if (I_clear_status) empty_read_d = 1'b0;

    if (I_flush) begin
      state_d       = ST_IDLE;
      index_d       = 2'd0;
      hold_d        = '0;
      entry_count_d = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (I_reg_rd) empty_read_d = 1'b1;
          if (!I_fifo_empty) begin
            fifo_rd = 1'b1;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (I_reg_rd) empty_read_d = 1'b1;
          hold_d  = I_fifo_dout;
          index_d = 2'd0;
          state_d = ST_READY;
        end
        ST_READY: begin
          if (I_reg_rd) begin
            if (index_q == 2'd2) begin
              index_d = 2'd0;
              if (entry_count_q != 16'hFFFF) entry_count_d = entry_count_q + 16'd1;
              // Prefetch the next entry while the host is still consuming this one.
              if (!I_fifo_empty) begin
                fifo_rd = 1'b1;
                state_d = ST_WAIT;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              index_d = index_q + 2'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      index_q       <= 2'd0;
      hold_q        <= '0;
      entry_count_q <= 16'd0;
      empty_read_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      hold_q        <= hold_d;
      entry_count_q <= entry_count_d;
      empty_read_q  <= empty_read_d;
    end
  end

  always_comb begin
    O_reg_data = 8'h00;
    if (state_q == ST_READY) begin
      case (index_q)
        2'd0:    O_reg_data = {1'b1, 5'b00000, hold_q[17:16]};
        2'd1:    O_reg_data = hold_q[15:8];
        2'd2:    O_reg_data = hold_q[7:0];
        default: O_reg_data = 8'h00;
      endcase
    end
  end

  // The read strobe is combinational, so it is masked while reset is held.
  assign O_fifo_rd     = fifo_rd & ~reset_i;
  assign O_empty_read  = empty_read_q;
  assign O_entry_count = entry_count_q;

endmodule
